// File: rtl/mem_lsu.sv
// rtl/mem_lsu.sv - MEM-stage load/store unit: word addressing, sub-word extract, RMW stores
//
// Takes one load/store at a time from EX/MEM, drives a word-wide RAM that has
// no byte enables (sub-word stores are done as read-modify-write) and returns
// a one-cycle response with extended load data and an error flag.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   req_valid/ready   request handshake (ready only while idle)
//   req_we            1 = store, 0 = load
//   req_funct3        000 B, 001 H, 010 W, 100 BU, 101 HU
//   req_addr          byte address
//   req_wdata         right-aligned store data
//   mem2ram_addr      word address to RAM
//   ram2mem_data      combinational RAM read data for mem2ram_addr
//   mem2ram_we        one-cycle write strobe
//   mem2ram_wdata     full word to write
//   resp_valid        one-cycle response pulse
//   resp_rdata        extended load data, 0 for stores and errors
//   resp_err          misaligned / out-of-range / illegal access
module mem_lsu #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [2:0]        req_funct3,
   input  logic [31:0]       req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic [ADDR_W-1:0] mem2ram_addr,
   input  logic [DATA_W-1:0] ram2mem_data,
   output logic              mem2ram_we,
   output logic [DATA_W-1:0] mem2ram_wdata,
   output logic              resp_valid,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              resp_err
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD   = 3'd1,
      S_STORE  = 3'd2,
      S_RMW_RD = 3'd3,
      S_RMW_WR = 3'd4,
      S_RESP   = 3'd5
   } state_t;

   state_t state, state_nxt;

   // Only the in-range part of the address is kept; the upper bits only feed
   // the error check at acceptance.
   logic [ADDR_W+1:0] addr_q;
   logic [2:0]        funct3_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] rdata_q;
   logic [DATA_W-1:0] merge_q;
   logic              err_q;

   logic              accept;
   logic              req_err;
   logic [7:0]        byte_sel;
   logic [15:0]       half_sel;
   logic [DATA_W-1:0] load_ext;
   logic [DATA_W-1:0] merged;

   assign accept = req_valid && (state == S_IDLE);

   // Error classification of the incoming request.
   always_comb begin
      req_err = 1'b0;
      case (req_funct3)
         3'b000:  req_err = 1'b0;
         3'b001:  req_err = req_addr[0];
         3'b010:  req_err = (req_addr[1:0] != 2'b00);
         3'b100:  req_err = req_we;
         3'b101:  req_err = req_we | req_addr[0];
         default: req_err = 1'b1;
      endcase
      if (req_addr[31:ADDR_W+2] != '0)
         req_err = 1'b1;
   end

   // Load extraction from the live RAM word; funct3[2] selects zero-extension.
   always_comb begin
      case (addr_q[1:0])
         2'd0:    byte_sel = ram2mem_data[7:0];
         2'd1:    byte_sel = ram2mem_data[15:8];
         2'd2:    byte_sel = ram2mem_data[23:16];
         default: byte_sel = ram2mem_data[31:24];
      endcase
      half_sel = addr_q[1] ? ram2mem_data[31:16] : ram2mem_data[15:0];
      case (funct3_q[1:0])
         2'b00:   load_ext = {{24{byte_sel[7] & ~funct3_q[2]}}, byte_sel};
         2'b01:   load_ext = {{16{half_sel[15] & ~funct3_q[2]}}, half_sel};
         default: load_ext = ram2mem_data;
      endcase
   end

   // Sub-word merge of store data into the word read during RMW_RD.
   always_comb begin
      merged = merge_q;
      if (funct3_q[1:0] == 2'b00) begin
         case (addr_q[1:0])
            2'd0:    merged[7:0]   = wdata_q[7:0];
            2'd1:    merged[15:8]  = wdata_q[7:0];
            2'd2:    merged[23:16] = wdata_q[7:0];
            default: merged[31:24] = wdata_q[7:0];
         endcase
      end else begin
         if (addr_q[1])
            merged[31:16] = wdata_q[15:0];
         else
            merged[15:0] = wdata_q[15:0];
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= S_IDLE;
      else
         state <= state_nxt;
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (req_valid) begin
               if (req_err)
                  state_nxt = S_RESP;
               else if (!req_we)
                  state_nxt = S_LOAD;
               else if (req_funct3 == 3'b010)
                  state_nxt = S_STORE;
               else
                  state_nxt = S_RMW_RD;
            end
         end
         S_LOAD:   state_nxt = S_RESP;
         S_STORE:  state_nxt = S_RESP;
         S_RMW_RD: state_nxt = S_RMW_WR;
         S_RMW_WR: state_nxt = S_RESP;
         S_RESP:   state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   // Outputs decoded from state; write strobe exists only in STORE/RMW_WR,
   // which an erroring request never reaches.
   always_comb begin
      req_ready     = (state == S_IDLE);
      resp_valid    = (state == S_RESP);
      mem2ram_we    = (state == S_STORE) || (state == S_RMW_WR);
      mem2ram_addr  = addr_q[ADDR_W+1:2];
      mem2ram_wdata = '0;
      if (state == S_STORE)
         mem2ram_wdata = wdata_q;
      else if (state == S_RMW_WR)
         mem2ram_wdata = merged;
      resp_rdata = (state == S_RESP) ? rdata_q : '0;
      resp_err   = (state == S_RESP) ? err_q : 1'b0;
   end

   // Request capture and data registers. rdata_q is cleared on accept so
   // stores and errors respond with zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q   <= '0;
         funct3_q <= '0;
         wdata_q  <= '0;
         err_q    <= 1'b0;
         rdata_q  <= '0;
         merge_q  <= '0;
      end else begin
         if (accept) begin
            addr_q   <= req_addr[ADDR_W+1:0];
            funct3_q <= req_funct3;
            wdata_q  <= req_wdata;
            err_q    <= req_err;
            rdata_q  <= '0;
         end
         if (state == S_LOAD)
            rdata_q <= load_ext;
         if (state == S_RMW_RD)
            merge_q <= ram2mem_data;
      end
   end

endmodule

// File: tb/tb_mem_lsu.sv
// tb/tb_mem_lsu.sv - randomized self-checking bench for mem_lsu against a byte-level memory model
module tb_mem_lsu;
   localparam int ADDR_W = 12;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              req_valid = 1'b0;
   logic              req_ready;
   logic              req_we = 1'b0;
   logic [2:0]        req_funct3 = 3'd0;
   logic [31:0]       req_addr = 32'd0;
   logic [31:0]       req_wdata = 32'd0;
   logic [ADDR_W-1:0] mem2ram_addr;
   logic [31:0]       ram2mem_data;
   logic              mem2ram_we;
   logic [31:0]       mem2ram_wdata;
   logic              resp_valid;
   logic [31:0]       resp_rdata;
   logic              resp_err;

   always #5 clk = ~clk;

   mem_lsu #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_we       (req_we),
      .req_funct3   (req_funct3),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .mem2ram_addr (mem2ram_addr),
      .ram2mem_data (ram2mem_data),
      .mem2ram_we   (mem2ram_we),
      .mem2ram_wdata(mem2ram_wdata),
      .resp_valid   (resp_valid),
      .resp_rdata   (resp_rdata),
      .resp_err     (resp_err)
   );

   // Word-wide RAM attached to the unit.
   logic [31:0] ram [0:4095];
   int          wr_total = 0;
   assign ram2mem_data = ram[mem2ram_addr];
   always @(posedge clk) begin
      if (mem2ram_we) begin
         ram[mem2ram_addr] <= mem2ram_wdata;
         wr_total          <= wr_total + 1;
      end
   end

   // Reference memory contents as the architecture sees them.
   logic [31:0] ref_mem [0:4095];

   int n_vec = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Architectural result of one access computed from address arithmetic.
   function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] wd, output logic err, output logic [31:0] rdata,
                                 output int lat, output logic [31:0] new_word);
      int unsigned size;
      int unsigned sh;
      logic [31:0] old, v, mask;
      size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
      err = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (we && f3[2]) ||
            ((a % size) != 0) || (a >= 32'd16384);
      rdata = 32'd0;
      new_word = 32'd0;
      lat = 1;
      if (err) return;
      old = ref_mem[a / 4];
      sh = 8 * (a % 4);
      if (!we) begin
         lat = 2;
         v = old >> sh;
         if (size == 1) begin
            v = v & 32'hFF;
            if (f3 == 3'd0 && v >= 32'd128) v = v - 32'd256;
         end else if (size == 2) begin
            v = v & 32'hFFFF;
            if (f3 == 3'd1 && v >= 32'd32768) v = v - 32'd65536;
         end
         rdata = v;
      end else begin
         lat = (size == 4) ? 2 : 3;
         mask = (size == 1) ? 32'hFF : (size == 2) ? 32'hFFFF : 32'hFFFFFFFF;
         new_word = (old & ~(mask << sh)) | ((wd & mask) << sh);
      end
   endfunction

   logic [31:0] last_rd, last_wa, last_wd;

   // One complete transaction with latency, data, error and write-port checks.
   task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd);
      logic        e_err;
      logic [31:0] e_rd, e_word;
      int          e_lat, lat, nwr;
      logic        busy_ready, got_resp, o_err;
      model(we, f3, a, wd, e_err, e_rd, e_lat, e_word);
      @(negedge clk);
      chk({tag, "_ready_idle"}, {31'd0, req_ready}, 32'd1);
      req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
      @(posedge clk);
      #1;
      req_valid = 1'b0; req_we = 1'($urandom); req_funct3 = 3'($urandom);
      req_addr = $urandom; req_wdata = $urandom;
      lat = 0; nwr = 0; busy_ready = 1'b0; got_resp = 1'b0;
      last_rd = 32'd0; o_err = 1'b0; last_wa = 32'd0; last_wd = 32'd0;
      while (lat < 10) begin
         @(negedge clk);
         lat++;
         if (req_ready) busy_ready = 1'b1;
         if (mem2ram_we) begin
            nwr++;
            last_wa = {20'd0, mem2ram_addr};
            last_wd = mem2ram_wdata;
         end
         if (resp_valid) begin
            got_resp = 1'b1;
            last_rd = resp_rdata;
            o_err = resp_err;
            break;
         end
      end
      chk({tag, "_resp_seen"}, {31'd0, got_resp}, 32'd1);
      chk({tag, "_latency"}, 32'(lat), 32'(e_lat));
      chk({tag, "_err"}, {31'd0, o_err}, {31'd0, e_err});
      chk({tag, "_rdata"}, last_rd, e_rd);
      chk({tag, "_busy_ready"}, {31'd0, busy_ready}, 32'd0);
      chk({tag, "_nwrites"}, 32'(nwr), (we && !e_err) ? 32'd1 : 32'd0);
      if (we && !e_err) begin
         chk({tag, "_waddr"}, last_wa, a / 4);
         chk({tag, "_wdata"}, last_wd, e_word);
         ref_mem[a / 4] = e_word;
      end
   endtask

   logic [31:0] bb_addr [0:2];

   initial begin
      int wt;
      int n_acc, n_resp, last_c;
      logic acc;
      logic        e_err;
      logic [31:0] e_rd, e_word;
      int          e_lat;
      logic [31:0] bb_exp [0:2];

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_ready", {31'd0, req_ready}, 32'd1);
      chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
      chk("rst_rdata", resp_rdata, 32'd0);
      chk("rst_err", {31'd0, resp_err}, 32'd0);
      chk("rst_we", {31'd0, mem2ram_we}, 32'd0);
      chk("rst_addr", {20'd0, mem2ram_addr}, 32'd0);
      chk("rst_wdata", mem2ram_wdata, 32'd0);
      rst_n = 1'b1;

      // Preload a working region through word stores
      for (int i = 0; i < 64; i++)
         do_req("pre", 1'b1, 3'b010, 32'(i * 4), $urandom);

      // Directed cases
      do_req("sw10", 1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
      chk("sw10_ramaddr", last_wa, 32'd4);
      do_req("lw10", 1'b0, 3'b010, 32'h10, 32'd0);
      chk("lw10_const", last_rd, 32'hDEADBEEF);
      do_req("sw0", 1'b1, 3'b010, 32'h0, 32'h80FF7F01);
      do_req("lb3", 1'b0, 3'b000, 32'h3, 32'd0);
      chk("lb3_const", last_rd, 32'hFFFFFF80);
      do_req("lbu3", 1'b0, 3'b100, 32'h3, 32'd0);
      chk("lbu3_const", last_rd, 32'h00000080);
      do_req("lh2", 1'b0, 3'b001, 32'h2, 32'd0);
      chk("lh2_const", last_rd, 32'hFFFF80FF);
      do_req("lhu0", 1'b0, 3'b101, 32'h0, 32'd0);
      chk("lhu0_const", last_rd, 32'h00007F01);
      do_req("sw0b", 1'b1, 3'b010, 32'h0, 32'h11223344);
      do_req("sb1", 1'b1, 3'b000, 32'h1, 32'h000000AA);
      chk("sb1_const", last_wd, 32'h1122AA44);
      do_req("sh2", 1'b1, 3'b001, 32'h2, 32'h0000BEEF);
      chk("sh2_const", last_wd, 32'hBEEFAA44);
      do_req("lw_mis", 1'b0, 3'b010, 32'h2, 32'd0);
      do_req("sh_mis", 1'b1, 3'b001, 32'h5, 32'h1234);
      do_req("lw_oor", 1'b0, 3'b010, 32'h4000, 32'd0);
      do_req("f3_011", 1'b0, 3'b011, 32'h8, 32'd0);
      do_req("sbu_bad", 1'b1, 3'b100, 32'h8, 32'h55);

      // Reset while the RMW read is in progress
      do_req("sw14", 1'b1, 3'b010, 32'h14, 32'h11223344);
      wt = wr_total;
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h15; req_wdata = 32'hAA;
      @(posedge clk);
      #1 req_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_ready", {31'd0, req_ready}, 32'd1);
      chk("mid_rst_resp_valid", {31'd0, resp_valid}, 32'd0);
      chk("mid_rst_rdata", resp_rdata, 32'd0);
      chk("mid_rst_err", {31'd0, resp_err}, 32'd0);
      chk("mid_rst_we", {31'd0, mem2ram_we}, 32'd0);
      chk("mid_rst_addr", {20'd0, mem2ram_addr}, 32'd0);
      chk("mid_rst_wdata", mem2ram_wdata, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("mid_rst_nowrite", 32'(wr_total), 32'(wt));
      chk("mid_rst_ramword", ram[5], 32'h11223344);
      do_req("lw14", 1'b0, 3'b010, 32'h14, 32'd0);

      // Back-to-back loads with req_valid held high
      for (int k = 0; k < 3; k++) begin
         bb_addr[k] = 32'((10 + k) * 4);
         model(1'b0, 3'b010, bb_addr[k], 32'd0, e_err, e_rd, e_lat, e_word);
         bb_exp[k] = e_rd;
      end
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = bb_addr[0];
      n_acc = 0; n_resp = 0; last_c = 0;
      for (int c = 0; c < 20 && n_resp < 3; c++) begin
         if (resp_valid) begin
            chk("bb_rdata", resp_rdata, bb_exp[n_resp]);
            chk("bb_ready_in_resp", {31'd0, req_ready}, 32'd0);
            if (n_resp > 0) chk("bb_spacing", 32'(c - last_c), 32'd3);
            else chk("bb_first_lat", 32'(c), 32'd2);
            last_c = c;
            n_resp++;
         end
         acc = req_ready && req_valid;
         @(negedge clk);
         if (acc) begin
            n_acc++;
            if (n_acc < 3) req_addr = bb_addr[n_acc];
            else req_valid = 1'b0;
         end
      end
      req_valid = 1'b0;
      chk("bb_nresp", 32'(n_resp), 32'd3);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         logic        we;
         logic [2:0]  f3;
         logic [31:0] a;
         logic [2:0]  legal [0:4];
         legal[0] = 3'b000; legal[1] = 3'b001; legal[2] = 3'b010;
         legal[3] = 3'b100; legal[4] = 3'b101;
         we = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 5) != 0) f3 = legal[$urandom_range(0, 4)];
         else f3 = 3'($urandom_range(0, 7));
         a = 32'(($urandom_range(0, 63) << 2) | $urandom_range(0, 3));
         if ($urandom_range(0, 15) == 0) a = a | (32'd1 << $urandom_range(14, 31));
         do_req("rnd", we, f3, a, $urandom);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
- Load/store unit of the MEM stage, directly upstream of the data RAM.
- Accepts one load/store request at a time from the EX/MEM pipeline register and converts the byte address into a word address for the RAM.
- Extracts and sign/zero-extends sub-word load data.
- Implements byte/halfword stores as read-modify-write (RAM is word-wide with no byte enables).
- Returns a single-cycle response to the WB side and flags misaligned or out-of-range accesses.

Parameters:
- ADDR_W, 12: RAM word-address width (4096 words).
- DATA_W, 32: word width; fixed at 32, not otherwise supported.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present from EX/MEM
- req_ready  out  1  unit can accept a request this cycle
- req_we  in  1  1=store, 0=load
- req_funct3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU loads only)
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- mem2ram_addr  out  ADDR_W  word address to RAM
- ram2mem_data  in  32  combinational RAM read data for mem2ram_addr
- mem2ram_we  out  1  write strobe, one cycle
- mem2ram_wdata  out  32  full word to write
- resp_valid  out  1  one-cycle response pulse
- resp_rdata  out  32  extended load data; 0 for stores/errors
- resp_err  out  1  misaligned or out-of-range; valid with resp_valid

Behaviour:
- Reset (async, rst_n=0) values:
  - State forced to IDLE.
  - req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0.
  - mem2ram_we=0, mem2ram_addr=0, mem2ram_wdata=0.
  - Internal request registers cleared.
  - Reset mid-operation abandons the access; a pending RMW write is never issued.
- Handshake:
  - Accept when req_valid && req_ready.
  - req_ready=1 only in IDLE.
  - Request fields are registered on acceptance; inputs are don't-care afterwards.
- Word address: mem2ram_addr = registered addr[ADDR_W+1:2].
- Error checks, evaluated on accepted address:
  - H/HU/store-H with addr[0]=1 -> err.
  - W with addr[1:0]!=0 -> err.
  - addr[31:ADDR_W+2]!=0 -> err.
  - funct3 011/110/111, or store with funct3 100/101 -> err.
- FSM states: IDLE, LOAD, STORE, RMW_RD, RMW_WR, RESP.
- Transitions out of IDLE on accept:
  - err -> RESP.
  - Load -> LOAD.
  - SW -> STORE.
  - SB/SH -> RMW_RD.
- Other transitions:
  - LOAD: capture extended ram2mem_data -> RESP.
  - STORE: mem2ram_we=1, mem2ram_wdata=req_wdata -> RESP.
  - RMW_RD: capture ram2mem_data into merge register -> RMW_WR.
  - RMW_WR: mem2ram_we=1, mem2ram_wdata=merged word -> RESP.
  - RESP: resp_valid=1 for exactly one cycle -> IDLE.
- Merge rule:
  - SB replaces byte addr[1:0] with req_wdata[7:0].
  - SH replaces half addr[1] with req_wdata[15:0].
  - Little-endian: byte 0 = bits[7:0].
- Load extraction: byte/half selected by addr[1:0]; B/H sign-extend, BU/HU zero-extend.
- Latency from accept cycle T:
  - error -> resp at T+1.
  - load or SW -> resp at T+2.
  - SB/SH -> resp at T+3.
- Back-to-back: a new request is accepted in the cycle after RESP (IDLE). No overlap and no bypass.
- mem2ram_we is never asserted on an erroring request or in any state other than STORE/RMW_WR.

Test Plan:
- Reset: rst_n low mid-RMW_RD -> all outputs zero, req_ready=1, no write issued; RAM word unchanged.
- SW addr 0x00000010 data 0xDEADBEEF, then LW same address -> mem2ram_addr=4, we pulse at T+1, LW resp_rdata=0xDEADBEEF at T+2.
- Word 0x80FF7F01 at word 0:
  - LB addr 3 -> 0xFFFFFF80.
  - LBU addr 3 -> 0x00000080.
  - LH addr 2 -> 0xFFFF80FF.
  - LHU addr 0 -> 0x00007F01.
- SB addr 1 data 0xAA onto 0x11223344 -> written word 0x1122AA44, resp at T+3. SH addr 2 data 0xBEEF -> 0xBEEFAA44.
- LW addr 0x2 and SH addr 0x5 -> resp_err=1 at T+1, mem2ram_we never high. LW addr 0x00004000 -> out-of-range err.
- req_valid held high for 3 LWs -> req_ready low except in IDLE; responses arrive every 3 cycles, in order, with correct data.
